// File: rtl/ram_arb_pkg.sv
// Shared sizing for the dual-port RAM arbiter and its round-robin picker.
package ram_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 15;
  localparam int DW_DEF   = 4;

  // Width of a requester index; never collapses to zero bits for a single requester.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDW_DEF = idWidth(NREQ_DEF);

endpackage

// File: rtl/rr_pick2.sv
// Round-robin picker: finds the first two requesters at or after the pointer.
module rr_pick2
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idWidth(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] win1_o,
  output logic [NREQ-1:0] win2_o,
  output logic            valid2_o
);

  logic [IW-1:0] idx;
  logic          have1;

  // Walk the requesters in rotated order starting at the pointer, taking the first two hits.
  always_comb begin
    win1_o   = '0;
    win2_o   = '0;
    valid2_o = 1'b0;
    have1    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_i) + k) % NREQ);
      if (req_i[idx]) begin
        if (!have1) begin
          win1_o[idx] = 1'b1;
          have1       = 1'b1;
        end else if (!valid2_o) begin
          win2_o[idx] = 1'b1;
          valid2_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dp_ram_arbiter_4r.sv
// Arbitrates NREQ requesters onto the two ports of a synchronous dual-port RAM
// and returns read data through a tagged three-stage pipeline per port.
module dp_ram_arbiter_4r
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ-1:0][AW-1:0]   addr,
  input  logic [NREQ-1:0][DW-1:0]   wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rvalid,
  output logic [NREQ-1:0][DW-1:0]   rdata,
  output logic                      rw_1,
  output logic                      rw_2,
  output logic [AW-1:0]             address_1,
  output logic [AW-1:0]             address_2,
  output logic [DW-1:0]             data_in_1,
  output logic [DW-1:0]             data_in_2,
  input  logic [DW-1:0]             data_out_1,
  input  logic [DW-1:0]             data_out_2
);

  localparam int IW = idWidth(NREQ);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] win1, win2;
  logic            valid2;
  logic [IW-1:0]   idx1, idx2, lastIdx;
  logic            conflict, grant1, grant2;
  logic [NREQ-1:0] rvNext;

  // Tag pipeline: index 0 follows RAM port 1, index 1 follows RAM port 2.
  logic [1:0]      s0Vld_q, s1Vld_q;
  logic [IW-1:0]   s0Id_q [2];
  logic [IW-1:0]   s1Id_q [2];

  function automatic logic [IW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (oh[k]) r = IW'(k);
    end
    return r;
  endfunction

  rr_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win1_o  (win1),
    .win2_o  (win2),
    .valid2_o(valid2)
  );

  // Drop the second winner when it touches the same word as the first and either one writes.
  always_comb begin
    idx1     = oh2idx(win1);
    idx2     = oh2idx(win2);
    conflict = valid2 && (addr[idx1] == addr[idx2]) && (we[idx1] || we[idx2]);
    grant1   = (|win1) && !rst;
    grant2   = valid2 && !conflict && !rst;
    gnt      = (grant1 ? win1 : '0) | (grant2 ? win2 : '0);
    lastIdx  = grant2 ? idx2 : idx1;
    ptr_d    = ptr_q;
    if (grant1) begin
      ptr_d = (lastIdx == IW'(NREQ - 1)) ? '0 : lastIdx + 1'b1;
    end
  end

  // Register the pointer and the RAM-side command for each port at the end of the grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rw_1      <= 1'b0;
      rw_2      <= 1'b0;
      address_1 <= '0;
      address_2 <= '0;
      data_in_1 <= '0;
      data_in_2 <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rw_1      <= grant1 ? we[idx1]    : 1'b0;
      address_1 <= grant1 ? addr[idx1]  : '0;
      data_in_1 <= grant1 ? wdata[idx1] : '0;
      rw_2      <= grant2 ? we[idx2]    : 1'b0;
      address_2 <= grant2 ? addr[idx2]  : '0;
      data_in_2 <= grant2 ? wdata[idx2] : '0;
    end
  end

  // Decode which requester the oldest tag stage belongs to, one flag per requester.
  always_comb begin
    rvNext = '0;
    for (int k = 0; k < NREQ; k++) begin
      rvNext[k] = (s1Vld_q[0] && (s1Id_q[0] == IW'(k))) ||
                  (s1Vld_q[1] && (s1Id_q[1] == IW'(k)));
    end
  end

  // Carry read tags alongside the RAM latency and land the data on the owning requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0Vld_q <= '0;
      s1Vld_q <= '0;
      s0Id_q  <= '{default: '0};
      s1Id_q  <= '{default: '0};
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      s0Vld_q[0] <= grant1 && !we[idx1];
      s0Vld_q[1] <= grant2 && !we[idx2];
      s0Id_q[0]  <= idx1;
      s0Id_q[1]  <= idx2;
      s1Vld_q    <= s0Vld_q;
      s1Id_q     <= s0Id_q;
      rvalid     <= rvNext;
      for (int k = 0; k < NREQ; k++) begin
        if (s1Vld_q[0] && (s1Id_q[0] == IW'(k))) begin
          rdata[k] <= data_out_1;
        end else if (s1Vld_q[1] && (s1Id_q[1] == IW'(k))) begin
          rdata[k] <= data_out_2;
        end
      end
    end
  end

endmodule

// File: tb/tb_dp_ram_arbiter_4r.sv
// Directed bench for dp_ram_arbiter_4r with a behavioural dual-port RAM and a
// scoreboard queue of expected read returns keyed by the cycle they are due.
module tb_dp_ram_arbiter_4r;

  localparam int NREQ = 4;
  localparam int AW   = 15;
  localparam int DW   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req, we;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][DW-1:0] wdata;
  logic [NREQ-1:0]         gnt, rvalid;
  logic [NREQ-1:0][DW-1:0] rdata;
  logic                    rw_1, rw_2;
  logic [AW-1:0]           address_1, address_2;
  logic [DW-1:0]           data_in_1, data_in_2;
  logic [DW-1:0]           data_out_1, data_out_2;

  typedef struct {
    int             due;
    int             id;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t            expQ[$];
  logic [DW-1:0]   expRd   [NREQ];
  logic [DW-1:0]   lastExp [NREQ];
  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [NREQ-1:0] monMatched;
  int              cyc = 0;
  int              nCompared = 0;
  int              nMismatched = 0;
  bit              monOn = 1'b0;

  dp_ram_arbiter_4r #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rw_1      (rw_1),
    .rw_2      (rw_2),
    .address_1 (address_1),
    .address_2 (address_2),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .data_out_1(data_out_1),
    .data_out_2(data_out_2)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp grants and schedule expected returns.
  always @(posedge clk) cyc <= cyc + 1;

  // Preload every RAM word with its low address nibble so unwritten reads are predictable.
  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] <= DW'(a & 15);
  end

  // Synchronous dual-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (rw_1) mem[address_1] <= data_in_1;
    if (rw_2) mem[address_2] <= data_in_2;
    data_out_1 <= mem[address_1];
    data_out_2 <= mem[address_2];
  end

  // A reset clears the returned data, so the held value the bench expects goes back to zero.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) lastExp[i] = '0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops every return due this cycle and flags any stray or changed output.
  always @(negedge clk) begin
    if (monOn) begin
      monMatched = '0;
      while (expQ.size() > 0 && expQ[0].due <= cyc) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("rvalid[%0d]", e.id), 32'(rvalid[e.id]), 32'd1);
        checkOutput($sformatf("rdata[%0d]", e.id), 32'(rdata[e.id]), 32'(e.data));
        lastExp[e.id] = e.data;
        monMatched[e.id] = 1'b1;
      end
      checkOutput("rvalidStray", 32'(rvalid & ~monMatched), 32'd0);
      for (int i = 0; i < NREQ; i++) begin
        if (!rvalid[i] && !monMatched[i]) begin
          checkOutput($sformatf("rdataHold[%0d]", i), 32'(rdata[i]), 32'(lastExp[i]));
        end
      end
    end
  end

  task automatic setReq(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] e);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    expRd[i] = e;
  endtask

  // One arbitration cycle: check grants, schedule expected reads, retire granted requesters.
  task automatic applyStimulus(input logic [NREQ-1:0] expGnt, input bit pushReads, input string tag);
    @(negedge clk);
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(expGnt));
    for (int i = 0; i < NREQ; i++) begin
      if (expGnt[i] && !we[i] && pushReads) begin
        exp_t e;
        e.due  = cyc + 3;
        e.id   = i;
        e.data = expRd[i];
        expQ.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (expGnt[i]) begin
        req[i] = 1'b0;
        we[i]  = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends even if the main sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      expRd[i]   = '0;
      lastExp[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Grants stay low while reset is held.
    req = 4'b1111;
    @(negedge clk);
    checkOutput("gntInReset", 32'(gnt), 32'd0);
    req = '0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    monOn = 1'b1;

    checkOutput("rst.rw_1", 32'(rw_1), 32'd0);
    checkOutput("rst.rw_2", 32'(rw_2), 32'd0);
    checkOutput("rst.address_1", 32'(address_1), 32'd0);
    checkOutput("rst.address_2", 32'(address_2), 32'd0);
    checkOutput("rst.data_in_1", 32'(data_in_1), 32'd0);
    checkOutput("rst.data_in_2", 32'(data_in_2), 32'd0);
    checkOutput("rst.rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst.rdata", 32'(rdata), 32'd0);
    checkOutput("rst.ptr", 32'(dut.ptr_q), 32'd0);

    // Reset then read: requester 0 writes 0xA to 0x0005, requester 1 reads it back.
    setReq(0, 1'b1, 15'h0005, 4'hA, 4'h0);
    applyStimulus(4'b0001, 1'b1, "wr0");
    checkOutput("wr0.rw_1", 32'(rw_1), 32'd1);
    checkOutput("wr0.address_1", 32'(address_1), 32'h5);
    checkOutput("wr0.data_in_1", 32'(data_in_1), 32'hA);
    checkOutput("wr0.rw_2", 32'(rw_2), 32'd0);
    checkOutput("wr0.address_2", 32'(address_2), 32'd0);
    setReq(1, 1'b0, 15'h0005, 4'h0, 4'hA);
    applyStimulus(4'b0010, 1'b1, "rd1");
    checkOutput("rd1.rw_1", 32'(rw_1), 32'd0);
    checkOutput("rd1.address_1", 32'(address_1), 32'h5);
    idle(6);

    // Dual grant from ptr=0 with all four requesting reads.
    doReset();
    checkOutput("dual.ptr0", 32'(dut.ptr_q), 32'd0);
    setReq(0, 1'b0, 15'h0010, 4'h0, 4'h0);
    setReq(1, 1'b0, 15'h0021, 4'h0, 4'h1);
    setReq(2, 1'b0, 15'h0032, 4'h0, 4'h2);
    setReq(3, 1'b0, 15'h0043, 4'h0, 4'h3);
    applyStimulus(4'b0011, 1'b1, "dual1");
    checkOutput("dual1.ptr", 32'(dut.ptr_q), 32'd2);
    checkOutput("dual1.address_1", 32'(address_1), 32'h10);
    checkOutput("dual1.address_2", 32'(address_2), 32'h21);
    setReq(0, 1'b0, 15'h0054, 4'h0, 4'h4);
    setReq(1, 1'b0, 15'h0065, 4'h0, 4'h5);
    applyStimulus(4'b1100, 1'b1, "dual2");
    checkOutput("dual2.ptr", 32'(dut.ptr_q), 32'd0);
    checkOutput("dual2.address_1", 32'(address_1), 32'h32);
    checkOutput("dual2.address_2", 32'(address_2), 32'h43);
    setReq(2, 1'b0, 15'h0076, 4'h0, 4'h6);
    setReq(3, 1'b0, 15'h0087, 4'h0, 4'h7);
    applyStimulus(4'b0011, 1'b1, "dual3");
    checkOutput("dual3.ptr", 32'(dut.ptr_q), 32'd2);
    applyStimulus(4'b1100, 1'b1, "dual4");
    checkOutput("dual4.ptr", 32'(dut.ptr_q), 32'd0);
    idle(6);

    // Same-address write/read conflict: only the writer wins, the reader retries and sees 0x3.
    setReq(2, 1'b1, 15'h7FFF, 4'h3, 4'h0);
    setReq(3, 1'b0, 15'h7FFF, 4'h0, 4'h3);
    applyStimulus(4'b0100, 1'b1, "conf1");
    checkOutput("conf1.ptr", 32'(dut.ptr_q), 32'd3);
    checkOutput("conf1.rw_2", 32'(rw_2), 32'd0);
    applyStimulus(4'b1000, 1'b1, "conf2");
    checkOutput("conf2.ptr", 32'(dut.ptr_q), 32'd0);
    idle(6);

    // Write and read to different addresses are both granted.
    setReq(0, 1'b1, 15'h0100, 4'h9, 4'h0);
    setReq(1, 1'b0, 15'h0200, 4'h0, 4'h0);
    applyStimulus(4'b0011, 1'b1, "noconf");
    checkOutput("noconf.rw_1", 32'(rw_1), 32'd1);
    checkOutput("noconf.rw_2", 32'(rw_2), 32'd0);
    checkOutput("noconf.address_2", 32'(address_2), 32'h200);
    checkOutput("noconf.ptr", 32'(dut.ptr_q), 32'd2);
    idle(6);

    // Two reads of the same address in one cycle return identical data together.
    setReq(0, 1'b0, 15'h1234, 4'h0, 4'h4);
    setReq(1, 1'b0, 15'h1234, 4'h0, 4'h4);
    applyStimulus(4'b0011, 1'b1, "same");
    idle(6);

    // Reset one cycle after a read grant: the read never returns.
    setReq(2, 1'b0, 15'h0050, 4'h0, 4'h0);
    applyStimulus(4'b0100, 1'b0, "midflight");
    doReset();
    checkOutput("midflight.ptr", 32'(dut.ptr_q), 32'd0);
    idle(8);

    // Streaming: requester 1 writes 16 words, then reads them back one per cycle.
    for (int k = 0; k < 16; k++) begin
      setReq(1, 1'b1, 15'h0300 + 15'(k), DW'(15 - k), 4'h0);
      applyStimulus(4'b0010, 1'b1, $sformatf("swr%0d", k));
    end
    for (int k = 0; k < 16; k++) begin
      setReq(1, 1'b0, 15'h0300 + 15'(k), 4'h0, DW'(15 - k));
      applyStimulus(4'b0010, 1'b1, $sformatf("srd%0d", k));
    end
    idle(8);

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
